// File: rtl/nios_pio_output_fifo.sv
// Avalon-MM write-side PIO: CPU pushes 32-bit words into a FIFO drained over valid/ready; 1-cycle registered reads.
// Push visible on out_valid one cycle later; a full FIFO drops writes (sticky overflow) unless a same-cycle pop frees a slot.
module nios_pio_output_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   wcnt_q, wcnt_d;
    logic [31:0]   readdata_q, readdata_d;

    logic        wr_en, push_req, ctrl_wr, flush, pop, push_acc;
    logic [31:0] status;

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign readdata  = readdata_q;

    assign wr_en    = chipselect & ~write_n;
    assign push_req = wr_en & (address == 2'd0);
    assign ctrl_wr  = wr_en & (address == 2'd2);
    assign flush    = ctrl_wr & writedata[1];
    // A pop that coincides with a flush is discarded along with the contents.
    assign pop      = out_valid & out_ready & ~flush;
    assign push_acc = push_req & ((count_q != FULL_CNT) | (out_valid & out_ready));

    always_comb begin
        status         = '0;
        status[AW:0]   = count_q;
        status[16]     = ~out_valid;
        status[17]     = (count_q == FULL_CNT);
        status[18]     = overflow_q;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wcnt_d     = wcnt_q;
        readdata_d = '0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_acc, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        if (push_req && !push_acc)
            overflow_d = 1'b1;
        else if (ctrl_wr && writedata[0])
            overflow_d = 1'b0;

        if (push_acc)
            wcnt_d = wcnt_q + 32'd1;
        else if (ctrl_wr && writedata[2])
            wcnt_d = '0;

        case (address)
            2'd0:    readdata_d = out_valid ? mem_q[rd_ptr_q] : 32'd0;
            2'd1:    readdata_d = status;
            2'd3:    readdata_d = wcnt_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wcnt_q     <= '0;
            readdata_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wcnt_q     <= wcnt_d;
            readdata_q <= readdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_acc) begin
            mem_q[wr_ptr_q] <= writedata;
        end
    end

endmodule

// File: tb/tb_nios_pio_output_fifo.sv
// Randomized and directed bench for nios_pio_output_fifo against a queue-based reference model.
module tb_nios_pio_output_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    nios_pio_output_fifo #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    logic [31:0] m_q[$];
    bit          m_ovf;
    logic [31:0] m_wcnt;
    logic [31:0] m_rd;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        int sz;
        sz = m_q.size();
        case (a)
            2'd0:    return (sz != 0) ? m_q[0] : 32'd0;
            2'd1:    return {13'd0, m_ovf, (sz == DEPTH), (sz == 0), 16'(sz)};
            2'd3:    return m_wcnt;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: the model consumes the inputs currently driven, then the DUT edge happens.
    task automatic tick();
        bit          wr, pop, flush;
        logic [31:0] nrd;
        wr    = chipselect && !write_n;
        pop   = (m_q.size() != 0) && out_ready;
        flush = wr && address == 2'd2 && writedata[1];
        nrd   = model_read(address);
        @(posedge clk);
        #1;
        m_rd = nrd;
        if (flush) begin
            m_q.delete();
        end else begin
            if (wr && address == 2'd0) begin
                if (m_q.size() < DEPTH || pop) begin
                    if (pop) begin
                        void'(m_q.pop_front());
                        pop = 0;
                    end
                    m_q.push_back(writedata);
                    m_wcnt = m_wcnt + 32'd1;
                end else begin
                    m_ovf = 1;
                end
            end
            if (pop) void'(m_q.pop_front());
        end
        if (wr && address == 2'd2) begin
            if (writedata[0]) m_ovf = 0;
            if (writedata[2]) m_wcnt = '0;
        end
    endtask

    task automatic idle();
        chipselect = 0; write_n = 1; address = 2'd0; writedata = '0; out_ready = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        tick();
        chipselect = 0; write_n = 1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1; write_n = 1; address = a;
        tick();
        chipselect = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        #2;
        m_q.delete(); m_ovf = 0; m_wcnt = '0; m_rd = '0;
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        #2;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %h expected 0", readdata); end
        m_q.delete(); m_ovf = 0; m_wcnt = '0; m_rd = '0;
        @(negedge clk);
        reset_n = 1;
        tick();
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0001_0000) begin n_fail++; $display("FAIL reset_status: got %h expected 00010000", readdata); end
    endtask

    task automatic test_basic();
        do_reset();
        chipselect = 1; write_n = 0; address = 2'd0; writedata = 32'hA5A5_0001;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b expected 0", out_valid); end
        tick();
        n_checks += 2;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_rise: got %b expected 1", out_valid); end
        if (out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL basic_head: got %h expected a5a50001", out_data); end
        bus_write(2'd0, 32'h0000_0002);
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0000_0002) begin n_fail++; $display("FAIL basic_status: got %h expected 00000002", readdata); end
        bus_read(2'd0);
        n_checks++;
        if (readdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL basic_peek: got %h expected a5a50001", readdata); end
        bus_read(2'd3);
        n_checks++;
        if (readdata !== 32'd2) begin n_fail++; $display("FAIL basic_counter: got %h expected 2", readdata); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus_write(2'd0, 32'h100 + i);
        bus_write(2'd0, 32'hDEAD_BEEF);
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0006_0004) begin n_fail++; $display("FAIL ovf_status: got %h expected 00060004", readdata); end
        bus_read(2'd3);
        n_checks++;
        if (readdata !== 32'd4) begin n_fail++; $display("FAIL ovf_counter: got %h expected 4", readdata); end
        bus_write(2'd2, 32'h1);
        bus_read(2'd1);
        n_checks += 2;
        if (readdata !== 32'h0002_0004) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00020004", readdata); end
        if (out_data !== 32'h100) begin n_fail++; $display("FAIL ovf_head: got %h expected 00000100", out_data); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_words [5];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            exp_words[i] = 32'h200 + i;
            bus_write(2'd0, exp_words[i]);
        end
        exp_words[4] = 32'hCAFE_0005;
        out_ready = 1;
        bus_write(2'd0, exp_words[4]);
        out_ready = 0;
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0002_0004) begin n_fail++; $display("FAIL fpp_status: got %h expected 00020004", readdata); end
        bus_read(2'd3);
        n_checks++;
        if (readdata !== 32'd5) begin n_fail++; $display("FAIL fpp_counter: got %h expected 5", readdata); end
        out_ready = 1;
        for (int i = 1; i < 5; i++) begin
            n_checks += 2;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_drain_valid[%0d]: got %b expected 1", i, out_valid); end
            if (out_data !== exp_words[i]) begin n_fail++; $display("FAIL fpp_drain_data[%0d]: got %h expected %h", i, out_data, exp_words[i]); end
            tick();
        end
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h300 + i);
        out_ready = 1;
        bus_write(2'd2, 32'h2);
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0001_0000) begin n_fail++; $display("FAIL flush_status: got %h expected 00010000", readdata); end
        chipselect = 1; write_n = 0; address = 2'd0; writedata = 32'h1234;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_prepush: got %b expected 0", out_valid); end
        tick();
        chipselect = 0; write_n = 1;
        n_checks += 2;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_push_valid: got %b expected 1", out_valid); end
        if (out_data !== 32'h1234) begin n_fail++; $display("FAIL flush_push_data: got %h expected 00001234", out_data); end
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_count: got %h expected 00000001", readdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h400 + i);
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0000_0003) begin n_fail++; $display("FAIL rmid_pre: got %h expected 00000003", readdata); end
        #2;
        reset_n = 0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL rmid_rd: got %h expected 0", readdata); end
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", out_data); end
        m_q.delete(); m_ovf = 0; m_wcnt = '0; m_rd = '0;
        @(negedge clk);
        reset_n = 1;
        tick();
        bus_read(2'd3);
        n_checks++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL rmid_counter: got %h expected 0", readdata); end
        bus_read(2'd1);
        n_checks++;
        if (readdata !== 32'h0001_0000) begin n_fail++; $display("FAIL rmid_status: got %h expected 00010000", readdata); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 1) != 0);
            out_ready  = ($urandom_range(0, 2) == 0);
            writedata  = $urandom;
            if (address == 2'd2)
                writedata = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 7) & 5);
            tick();
            n_checks += 2;
            if (out_valid !== (m_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, out_valid, m_q.size() != 0);
            end
            if (readdata !== m_rd) begin
                n_fail++; $display("FAIL rnd_readdata@%0d: got %h expected %h", c, readdata, m_rd);
            end
            if (m_q.size() != 0) begin
                n_checks++;
                if (out_data !== m_q[0]) begin
                    n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", c, out_data, m_q[0]);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 0;
        m_ovf = 0; m_wcnt = '0; m_rd = '0;
        #12;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
